onehot_req_encoder: RTL and testbench
=====================================

# onehot_req_encoder

- Registered request encoder: the inverse of the team's select-to-one-hot decoders.
- Takes an N-bit request vector and returns the binary index of the winning bit, plus hit and error status, through a one-deep valid/ready output register.
- Supports priority (first-match) and unique (exactly-one) semantics, selected per transaction, and keeps saturating event counters for no-match and multi-match.
- Sits between request sources (arbiter inputs, status decoders) and downstream index consumers.

## Interface
- N, 4: request vector width; legal 2..64.
- IDXW, $clog2(N): index width.
- CNT_W, 8: width of each event counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  request vector valid.
- in_ready  out  1  block can accept; equals !out_valid || out_ready.
- in_req  in  N  request vector.
- in_uniq  in  1  per-transaction mode: 1 = unique, 0 = priority.
- out_valid  out  1  encoded result valid.
- out_ready  in  1  downstream accepts result.
- out_idx  out  IDXW  index of lowest-numbered set bit.
- out_hit  out  1  at least one request bit set.
- out_err  out  2  enc_pkg::err_e status of the held result.
- clr_cnt  in  1  synchronous counter clear.
- nomatch_cnt  out  CNT_W  count of accepted all-zero vectors.
- multi_cnt  out  CNT_W  count of accepted multi-hot vectors in unique mode.

## Operation
- Accept occurs when in_valid && in_ready.
- On accept, the encoder result is registered into the output stage:
  - out_idx = lowest set bit index; bit 0 has highest priority.
  - out_hit = |in_req.
  - out_err is computed as follows.
- Zero vector, either mode: out_hit=0, out_idx=0, out_err=ERR_NOMATCH, nomatch_cnt increments.
- Priority mode, one or more bits set: out_err=ERR_NONE. Multi-hot is legal in this mode.
- Unique mode, exactly one bit set: out_err=ERR_NONE.
- Unique mode, two or more bits set:
  - out_err=ERR_MULTI, multi_cnt increments.
  - out_idx still reports the lowest set bit and out_hit=1. The result is never dropped.
- Output stage is a 2-state machine:
  - EMPTY (out_valid=0): accept -> FULL.
  - FULL (out_valid=1):
    - out_ready && accept -> stays FULL, new result loaded.
    - out_ready && !accept -> EMPTY.
    - !out_ready -> holds; out_idx, out_hit and out_err are stable.
- Counters saturate at 2^CNT_W-1 with no wrap.
- clr_cnt sets both counters to 0 on the next edge. When clear and increment happen in the same cycle, clear wins and the result is 0.
- in_req and in_uniq are sampled only on accept; they are don't-care otherwise.

## Timing
- Reset values: out_valid=0, out_idx=0, out_hit=0, out_err=ERR_NONE, nomatch_cnt=0, multi_cnt=0.
- in_ready is 1 during reset release, because out_valid=0.
- Reset asserted mid-transaction: the held result is discarded immediately (asynchronous). No partial state survives.
- Latency is 1 cycle: a vector accepted at edge k is visible on out_valid/out_* after edge k.
- Throughput is 1 result per cycle while out_ready=1.
- in_ready is combinational from out_ready. There is no combinational path from in_* to out_*.
- Counter update is visible on the edge that accepts the vector.

## Configuration
- Macro: ENC_UNIQUE_CHECK_EN.
- Defined:
  - Unique-mode multi-hot detection, ERR_MULTI, and multi_cnt are present as described.
- Undefined:
  - in_uniq is ignored and every transaction is treated as priority mode.
  - out_err is only ever ERR_NONE or ERR_NOMATCH.
  - multi_cnt is tied to 0 and the popcount logic is not built.
  - nomatch_cnt is unaffected.

## Structure
- Package enc_pkg:
  - typedef enum logic [1:0] err_e: ERR_NONE=2'b00, ERR_NOMATCH=2'b01, ERR_MULTI=2'b10.
  - Localparam CNT_W_DEF=8.
- Sub-module onehot_prio_enc (combinational, parameter N), instantiated once:
  - Outputs: idx (lowest set bit), any (|req), multi (more than one bit set).
  - The top level holds the output register, state, and counters.

## Test plan
- Reset, then in_req=4'b0100, in_uniq=1, out_ready=1 -> one cycle later out_idx=2, out_hit=1, out_err=ERR_NONE.
- in_req=4'b1010, in_uniq=0 -> out_idx=1, out_err=ERR_NONE, multi_cnt unchanged. Same vector with in_uniq=1 -> out_idx=1, out_err=ERR_MULTI, multi_cnt=1 (macro defined); out_err=ERR_NONE, multi_cnt=0 (macro undefined).
- in_req=4'b0000 -> out_hit=0, out_idx=0, out_err=ERR_NOMATCH, nomatch_cnt=1.
- Backpressure:
  - Hold out_ready=0 with a result FULL -> in_ready=0, outputs stable for 5 cycles.
  - Release -> back-to-back vectors 0001, 0010, 1000 emerge as idx 0, 1, 3, one per cycle.
- Send 260 zero vectors -> nomatch_cnt=255 (saturated). Assert clr_cnt together with a zero-vector accept -> nomatch_cnt=0.
- Assert rst_n=0 while FULL with out_ready=0 -> out_valid=0 and counters=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and defaults for the one-hot request encoder.
// Feature macro: ENC_UNIQUE_CHECK_EN enables unique-mode multi-hot detection.
package enc_pkg;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_NOMATCH = 2'b01,
    ERR_MULTI   = 2'b10
  } err_e;

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

  localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational lowest-index priority encoder with any/multi-hot flags.
// Feature macro: ENC_UNIQUE_CHECK_EN builds the multi-hot detector; otherwise multi is 0.
module onehot_prio_enc #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic [IDXW-1:0] idx,
  output logic            any,
  output logic            multi
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDXW'(i);
      end
    end
  end

  assign any = |req;

`ifdef ENC_UNIQUE_CHECK_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - N'(1)));
`else
  assign multi = 1'b0;
`endif

endmodule

// File: rtl/onehot_req_encoder.sv
// Registered request encoder: lowest set bit index, hit and error status behind a
// one-deep valid/ready stage, plus saturating event counters. Macro: ENC_UNIQUE_CHECK_EN.
module onehot_req_encoder
  import enc_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDXW  = $clog2(N),
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  input  logic             in_uniq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_hit,
  output err_e             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] nomatch_cnt,
  output logic [CNT_W-1:0] multi_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [IDXW-1:0] enc_idx;
  logic            enc_any;
  logic            enc_multi;
  logic            accept;

  out_state_e      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            hit_q, hit_d;
  err_e            err_q, err_d;
  logic [CNT_W-1:0] nomatch_q, nomatch_d;

  onehot_prio_enc #(
    .N    (N),
    .IDXW (IDXW)
  ) u_prio_enc (
    .req   (in_req),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  assign in_ready = (state_q == StEmpty) || out_ready;
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) state_d = StFull;
      end
      StFull: begin
        if (out_ready && !accept) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == StFull);
  end

  // Error classification of the incoming vector
  always_comb begin
    err_d = ERR_NONE;
    if (!enc_any) begin
      err_d = ERR_NOMATCH;
    end
`ifdef ENC_UNIQUE_CHECK_EN
    else if (in_uniq && enc_multi) begin
      err_d = ERR_MULTI;
    end
`endif
  end

  // Result register loads only on accept, so it stays stable under backpressure.
  always_comb begin
    idx_d = idx_q;
    hit_d = hit_q;
    if (accept) begin
      idx_d = enc_idx;
      hit_d = enc_any;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      hit_q <= 1'b0;
      err_q <= ERR_NONE;
    end else begin
      idx_q <= idx_d;
      hit_q <= hit_d;
      if (accept) begin
        err_q <= err_d;
      end
    end
  end

  assign out_idx = idx_q;
  assign out_hit = hit_q;
  assign out_err = err_q;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    nomatch_d = nomatch_q;
    if (clr_cnt) begin
      nomatch_d = '0;
    end else if (accept && !enc_any && (nomatch_q != CntMax)) begin
      nomatch_d = nomatch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nomatch_q <= '0;
    end else begin
      nomatch_q <= nomatch_d;
    end
  end

  assign nomatch_cnt = nomatch_q;

`ifdef ENC_UNIQUE_CHECK_EN
  logic [CNT_W-1:0] multi_q, multi_d;

  always_comb begin
    multi_d = multi_q;
    if (clr_cnt) begin
      multi_d = '0;
    end else if (accept && in_uniq && enc_multi && (multi_q != CntMax)) begin
      multi_d = multi_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_q <= '0;
    end else begin
      multi_q <= multi_d;
    end
  end

  assign multi_cnt = multi_q;
`else
  logic unused_uniq;
  assign unused_uniq = in_uniq ^ enc_multi;
  assign multi_cnt   = '0;
`endif

endmodule

// File: tb/tb_onehot_req_encoder.sv
// Directed self-checking bench for onehot_req_encoder (N=4, CNT_W=8).
module tb_onehot_req_encoder;
  import enc_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned IDXW  = 2;
  localparam int unsigned CNT_W = 8;

`ifdef ENC_UNIQUE_CHECK_EN
  localparam bit UniqEn = 1'b1;
`else
  localparam bit UniqEn = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_req;
  logic             in_uniq;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_hit;
  err_e             out_err;
  logic             clr_cnt;
  logic [CNT_W-1:0] nomatch_cnt;
  logic [CNT_W-1:0] multi_cnt;

  int checks;
  int failures;

  onehot_req_encoder #(
    .N     (N),
    .IDXW  (IDXW),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_req      (in_req),
    .in_uniq     (in_uniq),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_hit     (out_hit),
    .out_err     (out_err),
    .clr_cnt     (clr_cnt),
    .nomatch_cnt (nomatch_cnt),
    .multi_cnt   (multi_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector for a single cycle; caller ensures in_ready is high.
  task automatic send(input logic [N-1:0] req, input logic uniq);
    in_valid = 1'b1;
    in_req   = req;
    in_uniq  = uniq;
    step();
    in_valid = 1'b0;
    in_req   = '0;
    in_uniq  = 1'b0;
  endtask

  initial begin
    logic [1:0] held_err;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_req    = '0;
    in_uniq   = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_hit", 32'(out_hit), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'(ERR_NONE));
    chk("rst_nomatch", 32'(nomatch_cnt), 32'd0);
    chk("rst_multi", 32'(multi_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Single hot in unique mode
    send(4'b0100, 1'b1);
    chk("u0100_valid", 32'(out_valid), 32'd1);
    chk("u0100_idx", 32'(out_idx), 32'd2);
    chk("u0100_hit", 32'(out_hit), 32'd1);
    chk("u0100_err", 32'(out_err), 32'(ERR_NONE));

    // Multi-hot in priority mode is legal
    send(4'b1010, 1'b0);
    chk("p1010_idx", 32'(out_idx), 32'd1);
    chk("p1010_err", 32'(out_err), 32'(ERR_NONE));
    chk("p1010_multi", 32'(multi_cnt), 32'd0);

    // Multi-hot in unique mode
    send(4'b1010, 1'b1);
    chk("u1010_idx", 32'(out_idx), 32'd1);
    chk("u1010_hit", 32'(out_hit), 32'd1);
    chk("u1010_err", 32'(out_err), UniqEn ? 32'(ERR_MULTI) : 32'(ERR_NONE));
    chk("u1010_multi", 32'(multi_cnt), UniqEn ? 32'd1 : 32'd0);

    // Zero vector
    send(4'b0000, 1'b1);
    chk("z_hit", 32'(out_hit), 32'd0);
    chk("z_idx", 32'(out_idx), 32'd0);
    chk("z_err", 32'(out_err), 32'(ERR_NOMATCH));
    chk("z_nomatch", 32'(nomatch_cnt), 32'd1);

    // Backpressure: load 0100 then stall with a competing vector offered
    send(4'b0100, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_req   = 4'b1111;
    in_uniq  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_idx", 32'(out_idx), 32'd2);
      chk("bp_err", 32'(out_err), 32'(ERR_NONE));
    end
    chk("bp_multi_hold", 32'(multi_cnt), UniqEn ? 32'd1 : 32'd0);

    // Release: back-to-back vectors, one result per cycle
    out_ready = 1'b1;
    in_uniq   = 1'b0;
    in_req    = 4'b0001;
    step();
    chk("b2b_idx0", 32'(out_idx), 32'd0);
    chk("b2b_valid0", 32'(out_valid), 32'd1);
    in_req = 4'b0010;
    step();
    chk("b2b_idx1", 32'(out_idx), 32'd1);
    in_req = 4'b1000;
    step();
    chk("b2b_idx3", 32'(out_idx), 32'd3);
    chk("b2b_valid3", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    in_req   = '0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_nomatch", 32'(nomatch_cnt), 32'd1);

    // Saturation: 1 + 260 zero vectors clamps at 255
    in_valid = 1'b1;
    in_req   = '0;
    for (int i = 0; i < 260; i++) begin
      step();
    end
    chk("sat_nomatch", 32'(nomatch_cnt), 32'd255);
    chk("sat_err", 32'(out_err), 32'(ERR_NOMATCH));

    // Clear wins over a same-cycle increment
    clr_cnt = 1'b1;
    step();
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    chk("clr_nomatch", 32'(nomatch_cnt), 32'd0);
    chk("clr_multi", 32'(multi_cnt), 32'd0);
    step();

    // Asynchronous reset while full and stalled
    send(4'b0000, 1'b0);
    send(4'b1010, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_nomatch", 32'(nomatch_cnt), 32'd1);
    held_err = out_err;
    chk("pre_rst_err", 32'(held_err), UniqEn ? 32'(ERR_MULTI) : 32'(ERR_NONE));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_nomatch", 32'(nomatch_cnt), 32'd0);
    chk("arst_multi", 32'(multi_cnt), 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_err", 32'(out_err), 32'(ERR_NONE));
    chk("arst_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
